// File: rtl/cntrl_spi_slave.sv
// SPI mode-0 responder on oversampled SCK/MOSI; frames (no chip select, idle-timeout delimited)
// become single-cycle register read/write strobes with burst auto-increment.
`timescale 1ns/1ps
module cntrl_spi_slave #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 7,
   parameter int TIMEOUT    = 1024,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk_250mhz,
   input  logic                  rst_250mhz,
   input  logic                  cntrl_sck,
   input  logic                  cntrl_mosi,
   output logic                  cntrl_miso,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [DATA_WIDTH-1:0] reg_wr_data,
   output logic                  reg_wr_en,
   output logic                  reg_rd_en,
   input  logic [DATA_WIDTH-1:0] reg_rd_data,
   output logic                  busy,
   output logic                  frame_err
);
   localparam int CMD_WIDTH = ADDR_WIDTH + 1;
   localparam int CNT_W     = $clog2(DATA_WIDTH + 1);
   localparam int TO_W      = $clog2(TIMEOUT + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMD  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   logic                  r_sck_s1, r_sck_s2, r_sck_d;
   logic                  r_mosi_s1, r_mosi_s2;
   logic                  w_rise, w_fall, w_timeout, w_shift_out;
   logic [1:0]            r_state;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_rnw;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [TO_W-1:0]       r_idle_cnt;
   logic                  r_wr_pend, r_rd_pend;
   logic [RD_LATENCY-1:0] r_rd_pipe;
   logic [DATA_WIDTH-1:0] r_miso_shreg;

   always_ff @(posedge clk_250mhz or posedge rst_250mhz) begin
      if (rst_250mhz) begin
         r_sck_s1  <= 1'b0;
         r_sck_s2  <= 1'b0;
         r_sck_d   <= 1'b0;
         r_mosi_s1 <= 1'b0;
         r_mosi_s2 <= 1'b0;
      end else begin
         r_sck_s1  <= cntrl_sck;
         r_sck_s2  <= r_sck_s1;
         r_sck_d   <= r_sck_s2;
         r_mosi_s1 <= cntrl_mosi;
         r_mosi_s2 <= r_mosi_s1;
      end
   end

   assign w_rise      = r_sck_s2 & ~r_sck_d;
   assign w_fall      = ~r_sck_s2 & r_sck_d;
   assign w_timeout   = (r_state != ST_IDLE) && (r_idle_cnt == TO_W'(TIMEOUT));
   assign w_shift_out = (r_state == ST_DATA) && r_rnw && w_fall && !w_timeout;
   assign busy        = (r_state != ST_IDLE);

   always_ff @(posedge clk_250mhz or posedge rst_250mhz) begin
      if (rst_250mhz) begin
         r_idle_cnt <= '0;
      end else if ((r_state == ST_IDLE) || w_rise || w_fall || w_timeout) begin
         r_idle_cnt <= '0;
      end else begin
         r_idle_cnt <= r_idle_cnt + TO_W'(1);
      end
   end

   // Strobes are issued one cycle after the bit that completes a byte/word.
   always_ff @(posedge clk_250mhz or posedge rst_250mhz) begin
      if (rst_250mhz) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_rnw       <= 1'b0;
         r_addr      <= '0;
         r_wr_pend   <= 1'b0;
         r_rd_pend   <= 1'b0;
         reg_addr    <= '0;
         reg_wr_data <= '0;
         reg_wr_en   <= 1'b0;
         reg_rd_en   <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         reg_wr_en <= 1'b0;
         reg_rd_en <= 1'b0;
         frame_err <= 1'b0;
         r_wr_pend <= 1'b0;
         r_rd_pend <= 1'b0;
         if (r_wr_pend) begin
            reg_wr_en   <= 1'b1;
            reg_addr    <= r_addr;
            reg_wr_data <= r_shift;
            r_addr      <= r_addr + ADDR_WIDTH'(1);
         end
         if (r_rd_pend) begin
            reg_rd_en <= 1'b1;
            reg_addr  <= r_addr;
            r_addr    <= r_addr + ADDR_WIDTH'(1);
         end
         if (w_timeout) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            frame_err <= (r_bit_cnt != '0);
         end else if (w_rise) begin
            r_shift <= {r_shift[DATA_WIDTH-2:0], r_mosi_s2};
            case (r_state)
               ST_IDLE: begin
                  r_state   <= ST_CMD;
                  r_bit_cnt <= CNT_W'(1);
               end
               ST_CMD: begin
                  if (r_bit_cnt == CNT_W'(CMD_WIDTH - 1)) begin
                     r_state   <= ST_DATA;
                     r_bit_cnt <= '0;
                     r_rnw     <= r_shift[ADDR_WIDTH-1];
                     r_addr    <= {r_shift[ADDR_WIDTH-2:0], r_mosi_s2};
                     r_rd_pend <= r_shift[ADDR_WIDTH-1];
                  end else begin
                     r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  end
               end
               ST_DATA: begin
                  if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                     r_bit_cnt <= '0;
                     r_rd_pend <= r_rnw;
                     r_wr_pend <= ~r_rnw;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   // Read word is captured RD_LATENCY cycles after the strobe, before the next SCK fall.
   always_ff @(posedge clk_250mhz or posedge rst_250mhz) begin
      if (rst_250mhz) begin
         r_rd_pipe    <= '0;
         r_miso_shreg <= '0;
         cntrl_miso   <= 1'b0;
      end else begin
         r_rd_pipe[0] <= reg_rd_en;
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_rd_pipe[i] <= r_rd_pipe[i-1];
         end
         if (r_rd_pipe[RD_LATENCY-1]) begin
            r_miso_shreg <= reg_rd_data;
         end else if (w_shift_out) begin
            r_miso_shreg <= {r_miso_shreg[DATA_WIDTH-2:0], 1'b0};
         end
         if (w_timeout || (r_state != ST_DATA) || !r_rnw) begin
            cntrl_miso <= 1'b0;
         end else if (w_fall) begin
            cntrl_miso <= r_miso_shreg[DATA_WIDTH-1];
         end
      end
   end
endmodule
